// File: rtl/mem_stage_pkg.sv
// Shared MIPS P7 definitions: memory opcodes, exception codes and the data-side address map.
package mips_defs;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] ADDR_EXC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] ADDR_DM_TOP      = 32'h0000_2FFF;
  localparam logic [31:0] ADDR_TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] ADDR_TIMER1_BASE = 32'h0000_7F10;
  localparam logic [31:0] ADDR_IG_BASE     = 32'h0000_7F20;
  localparam logic [31:0] TIMER_WIN_BYTES  = 32'd12;
  localparam logic [31:0] IG_WIN_BYTES     = 32'd4;
  localparam logic [31:0] TIMER_COUNT_OFF  = 32'd8;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  function automatic acc_size_e acc_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:          return SZ_WORD;
      OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
      OP_LB, OP_LBU, OP_SB:  return SZ_BYTE;
      default:               return SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_ext.sv
// Load extender: selects the addressed half/byte of the read word and sign/zero-extends it.
module mem_ext
  import mips_defs::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
  end

  always_comb begin
    ldata_o = rdata_i;
    case (op_i)
      OP_LH:   ldata_o = {{16{half[15]}}, half};
      OP_LHU:  ldata_o = {16'h0000, half};
      OP_LB:   ldata_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ldata_o = {24'h00_0000, byte_sel};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// P7 memory stage: E/M pipeline register, address-exception detection, store lane
// steering and load extension.
module mem_stage
  import mips_defs::*;
#(
  parameter logic [31:0] EXC_HANDLER = ADDR_EXC_HANDLER,
  parameter logic [31:0] DM_TOP      = ADDR_DM_TOP,
  parameter logic [31:0] TIMER0_BASE = ADDR_TIMER0_BASE,
  parameter logic [31:0] TIMER1_BASE = ADDR_TIMER1_BASE,
  parameter logic [31:0] IG_BASE     = ADDR_IG_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] e_instr,
  input  logic [31:0] e_aluout,
  input  logic [31:0] e_DMinput,
  input  logic [31:0] em_out,
  input  logic [4:0]  em_exc,
  input  logic [31:0] e_pc,
  input  logic        e_bd,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_instr,
  output logic [31:0] m_pc,
  output logic        m_bd,
  output logic [31:0] m_out,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_wdata,
  output logic [31:0] m_ldata,
  output logic [4:0]  m_exc
);

  logic [31:0] instr_q, pc_q, out_q, addr_q, sdata_q;
  logic [31:0] instr_d, pc_d, out_d, addr_d, sdata_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;

  always_comb begin
    if (req) begin
      instr_d = '0;
      pc_d    = EXC_HANDLER;
      bd_d    = 1'b0;
      out_d   = '0;
      addr_d  = '0;
      sdata_d = '0;
      exc_d   = EXC_NONE;
    end else begin
      instr_d = e_instr;
      pc_d    = e_pc;
      bd_d    = e_bd;
      out_d   = em_out;
      addr_d  = e_aluout;
      sdata_d = e_DMinput;
      exc_d   = em_exc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
      out_q   <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      exc_q   <= exc_d;
    end
  end

  logic [5:0] op;
  acc_size_e  sz;
  logic       is_load, is_store;
  logic       in_dm, in_t0, in_t1, in_ig, in_dev;
  logic       misalign, narrow_dev, out_of_range, count_wr;

  always_comb begin
    op       = instr_q[31:26];
    sz       = acc_size(op);
    is_load  = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);

    in_dm  = addr_q <= DM_TOP;
    in_t0  = (addr_q >= TIMER0_BASE) && (addr_q < TIMER0_BASE + TIMER_WIN_BYTES);
    in_t1  = (addr_q >= TIMER1_BASE) && (addr_q < TIMER1_BASE + TIMER_WIN_BYTES);
    in_ig  = (addr_q >= IG_BASE) && (addr_q < IG_BASE + IG_WIN_BYTES);
    in_dev = in_t0 || in_t1 || in_ig;

    misalign     = ((sz == SZ_WORD) && (addr_q[1:0] != 2'b00)) ||
                   ((sz == SZ_HALF) && addr_q[0]);
    narrow_dev   = in_dev && (sz != SZ_WORD);
    out_of_range = !(in_dm || in_dev);
    // Timer Count occupies the last word of each timer window and is read-only.
    count_wr     = (in_t0 && (addr_q >= TIMER0_BASE + TIMER_COUNT_OFF)) ||
                   (in_t1 && (addr_q >= TIMER1_BASE + TIMER_COUNT_OFF));
  end

  always_comb begin
    m_exc = EXC_NONE;
    if (exc_q != EXC_NONE)
      m_exc = exc_q;
    else if (is_load && (misalign || narrow_dev || out_of_range))
      m_exc = EXC_ADEL;
    else if (is_store && (misalign || narrow_dev || out_of_range || count_wr))
      m_exc = EXC_ADES;
  end

  always_comb begin
    m_byteen = '0;
    if (is_store && (m_exc == EXC_NONE) && !req) begin
      case (sz)
        SZ_WORD: m_byteen = '1;
        SZ_HALF: m_byteen = 4'b0011 << addr_q[1:0];
        SZ_BYTE: m_byteen = 4'b0001 << addr_q[1:0];
        default: m_byteen = '0;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_SH:   m_wdata = {2{sdata_q[15:0]}};
      OP_SB:   m_wdata = {4{sdata_q[7:0]}};
      default: m_wdata = sdata_q;
    endcase
  end

  mem_ext u_mem_ext (
    .addr_lo_i (addr_q[1:0]),
    .op_i      (op),
    .rdata_i   (m_rdata),
    .ldata_o   (m_ldata)
  );

  assign m_instr = instr_q;
  assign m_pc    = pc_q;
  assign m_bd    = bd_q;
  assign m_out   = out_q;
  assign m_addr  = addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded random bench for mem_stage against a behavioural memory-stage model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, req;
  logic [31:0] e_instr, e_aluout, e_DMinput, em_out, e_pc, m_rdata;
  logic [4:0]  em_exc;
  logic        e_bd;
  logic [31:0] m_instr, m_pc, m_out, m_addr, m_wdata, m_ldata;
  logic        m_bd;
  logic [3:0]  m_byteen;
  logic [4:0]  m_exc;

  always #5 clk = ~clk;

  mem_stage #(
    .EXC_HANDLER (32'h0000_4180),
    .DM_TOP      (32'h0000_2FFF),
    .TIMER0_BASE (32'h0000_7F00),
    .TIMER1_BASE (32'h0000_7F10),
    .IG_BASE     (32'h0000_7F20)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .e_instr(e_instr), .e_aluout(e_aluout), .e_DMinput(e_DMinput),
    .em_out(em_out), .em_exc(em_exc), .e_pc(e_pc), .e_bd(e_bd),
    .m_rdata(m_rdata),
    .m_instr(m_instr), .m_pc(m_pc), .m_bd(m_bd), .m_out(m_out),
    .m_addr(m_addr), .m_byteen(m_byteen), .m_wdata(m_wdata),
    .m_ldata(m_ldata), .m_exc(m_exc)
  );

  typedef struct {
    logic [31:0] instr, alu, din, out, pc, rdata;
    logic [4:0]  exc;
    logic        bd, req;
  } stim_t;

  typedef struct {
    logic [31:0] instr, pc, out, addr, wdata, ldata;
    logic        bd;
    logic [3:0]  be;
    logic [4:0]  exc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: memory-access rules written as size/offset arithmetic over the address map.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [5:0] op;
    logic [31:0] a;
    int unsigned size, off;
    bit ld, st, dm, t0, t1, ig, bad;
    logic [15:0] h;
    logic [7:0] b;
    if (s.req) begin
      e.instr = 0; e.pc = 32'h0000_4180; e.bd = 0; e.out = 0; e.addr = 0;
      e.exc = 0; e.be = 0; e.wdata = 0; e.ldata = s.rdata;
      return e;
    end
    e.instr = s.instr; e.pc = s.pc; e.bd = s.bd; e.out = s.out; e.addr = s.alu;
    op  = s.instr[31:26];
    a   = s.alu;
    off = a % 4;
    ld  = op inside {6'h23, 6'h21, 6'h25, 6'h20, 6'h24};
    st  = op inside {6'h2B, 6'h29, 6'h28};
    size = (op == 6'h23 || op == 6'h2B) ? 4 : (op inside {6'h21, 6'h25, 6'h29}) ? 2 : 1;
    dm  = a <= 32'h0000_2FFF;
    t0  = a >= 32'h0000_7F00 && a < 32'h0000_7F0C;
    t1  = a >= 32'h0000_7F10 && a < 32'h0000_7F1C;
    ig  = a >= 32'h0000_7F20 && a < 32'h0000_7F24;
    bad = (a % size != 0) || !(dm || t0 || t1 || ig) || (size != 4 && !dm);
    if (st && ((t0 && a >= 32'h0000_7F08) || (t1 && a >= 32'h0000_7F18))) bad = 1;
    e.exc = (s.exc != 0) ? s.exc : (ld && bad) ? 5'd4 : (st && bad) ? 5'd5 : 5'd0;
    e.be = 4'h0;
    if (st && e.exc == 0)
      e.be = (size == 4) ? 4'hF : (size == 2) ? 4'(3 << off) : 4'(1 << off);
    case (op)
      6'h29:   e.wdata = {2{s.din[15:0]}};
      6'h28:   e.wdata = {4{s.din[7:0]}};
      default: e.wdata = s.din;
    endcase
    h = 16'(s.rdata >> (16 * (off / 2)));
    b = 8'(s.rdata >> (8 * off));
    case (op)
      6'h21:   e.ldata = {{16{h[15]}}, h};
      6'h25:   e.ldata = {16'h0, h};
      6'h20:   e.ldata = {{24{b[7]}}, b};
      6'h24:   e.ldata = {24'h0, b};
      default: e.ldata = s.rdata;
    endcase
    return e;
  endfunction

  function automatic stim_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] din,
                               input logic [4:0] exc, input logic [31:0] rdata, input logic rq);
    stim_t s;
    s.instr = {op, 26'($urandom)};
    s.alu = a; s.din = din; s.exc = exc; s.rdata = rdata; s.req = rq;
    s.out = $urandom; s.pc = $urandom; s.bd = 1'($urandom);
    return s;
  endfunction

  function automatic stim_t rnd();
    logic [5:0] ops [11] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28,
                             6'h00, 6'h0D, 6'h0F};
    logic [31:0] a;
    logic [4:0] ex;
    int unsigned r;
    case ($urandom_range(0, 5))
      0: a = $urandom_range(0, 32'h2FFF);
      1: a = 32'h0000_2FF8 + $urandom_range(0, 15);
      2: a = 32'h0000_7F00 + $urandom_range(0, 15);
      3: a = 32'h0000_7F10 + $urandom_range(0, 15);
      4: a = 32'h0000_7F20 + $urandom_range(0, 7);
      default: a = $urandom;
    endcase
    r  = $urandom_range(0, 9);
    ex = (r == 0) ? 5'd12 : (r == 1) ? 5'd4 : 5'd0;
    return mk(ops[$urandom_range(0, 10)], a, $urandom, ex, $urandom,
              $urandom_range(0, 15) == 0);
  endfunction

  task automatic issue(input stim_t s);
    @(negedge clk);
    e_instr = s.instr; e_aluout = s.alu; e_DMinput = s.din; em_out = s.out;
    em_exc = s.exc; e_pc = s.pc; e_bd = s.bd; m_rdata = s.rdata; req = s.req;
    q.push_back(model(s));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instr",  m_instr, e.instr);
        chk("pc",     m_pc, e.pc);
        chk("bd",     {31'b0, m_bd}, {31'b0, e.bd});
        chk("out",    m_out, e.out);
        chk("addr",   m_addr, e.addr);
        chk("byteen", {28'b0, m_byteen}, {28'b0, e.be});
        chk("wdata",  m_wdata, e.wdata);
        chk("ldata",  m_ldata, e.ldata);
        chk("exc",    {27'b0, m_exc}, {27'b0, e.exc});
      end
    end
  end

  initial begin : req_gate_monitor
    forever begin
      @(negedge clk);
      #1;
      if (req === 1'b1) chk("byteen_req_gate", {28'b0, m_byteen}, 32'h0);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"}, m_instr, 32'h0);
    chk({tag, "_pc"},    m_pc, 32'h0);
    chk({tag, "_bd"},    {31'b0, m_bd}, 32'h0);
    chk({tag, "_out"},   m_out, 32'h0);
    chk({tag, "_addr"},  m_addr, 32'h0);
    chk({tag, "_wdata"}, m_wdata, 32'h0);
    chk({tag, "_exc"},   {27'b0, m_exc}, 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b0; req = 1'b0;
    e_instr = '0; e_aluout = '0; e_DMinput = '0; em_out = '0;
    em_exc = '0; e_pc = '0; e_bd = 1'b0; m_rdata = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    issue(mk(6'h2B, 32'h0000_0104, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0));
    issue(mk(6'h28, 32'h0000_0103, 32'h0000_00A5, 5'd0, 32'h0, 1'b0));
    issue(mk(6'h21, 32'h0000_0002, 32'h0, 5'd0, 32'h8001_1234, 1'b0));
    issue(mk(6'h25, 32'h0000_0002, 32'h0, 5'd0, 32'h8001_1234, 1'b0));
    issue(mk(6'h23, 32'h0000_0006, 32'h0, 5'd0, 32'h1234_5678, 1'b0));
    issue(mk(6'h2B, 32'h0000_7F08, 32'h1, 5'd0, 32'h0, 1'b0));
    issue(mk(6'h29, 32'h0000_7F20, 32'h1, 5'd0, 32'h0, 1'b0));
    issue(mk(6'h2B, 32'h0000_0001, 32'h1, 5'd12, 32'h0, 1'b0));
    issue(mk(6'h2B, 32'h0000_2FFC, 32'h55AA_00FF, 5'd0, 32'h0, 1'b0));
    issue(mk(6'h23, 32'h0000_3000, 32'h0, 5'd0, 32'h0, 1'b0));
    issue(mk(6'h2B, 32'h0000_7F04, 32'h7, 5'd0, 32'h0, 1'b0));
    issue(mk(6'h23, 32'h0000_7F20, 32'h0, 5'd0, 32'hCAFE_F00D, 1'b0));
    issue(mk(6'h20, 32'h0000_0011, 32'h0, 5'd0, 32'h0000_9A00, 1'b0));
    issue(mk(6'h2B, 32'h0000_0200, 32'h0BAD_CAFE, 5'd0, 32'h0, 1'b0));
    issue(mk(6'h00, 32'h0000_0000, 32'h0, 5'd0, 32'h0, 1'b1));
    issue(mk(6'h00, 32'h0000_0000, 32'h0, 5'd0, 32'h0, 1'b0));

    for (int i = 0; i < 400; i++) issue(rnd());

    @(posedge clk);
    #3;
    req = 1'b0;
    reset = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 100; i++) issue(rnd());

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the P7 five-stage MIPS pipeline. Sits directly downstream of the Execute stage and owns the E/M pipeline register.
- Drives the data-memory/bridge access: address, byte enables, and aligned write data.
- Sign/zero-extends load data.
- Detects load/store address exceptions (AdEL=4, AdES=5), merges them with upstream exception codes, and passes the result to CP0 and the W stage.

Parameters:
- EXC_HANDLER, 32'h0000_4180, PC value loaded into the stage when the register is flushed by req.
- DM_TOP, 32'h0000_2FFF, last valid data-memory byte address.
- TIMER0_BASE, 32'h0000_7F00, timer0 window base; window is 12 bytes.
- TIMER1_BASE, 32'h0000_7F10, timer1 window base; window is 12 bytes.
- IG_BASE, 32'h0000_7F20, interrupt-generator window base; window is 4 bytes.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  1  CP0 exception/interrupt request; flushes the stage.
- e_instr  in  32  instruction leaving E.
- e_aluout  in  32  effective address / ALU result.
- e_DMinput  in  32  forwarded rt store data.
- em_out  in  32  E-stage forwarding value (jal link / hi / lo / alu).
- em_exc  in  5  exception code from E (0 = none).
- e_pc  in  32  PC of the instruction in E.
- e_bd  in  1  branch-delay-slot flag.
- m_rdata  in  32  word read from DM/bridge (combinational, same cycle).
- m_instr  out  32  registered instruction.
- m_pc  out  32  registered PC (to CP0 EPC / macroscopic PC).
- m_bd  out  1  registered BD flag.
- m_out  out  32  registered em_out (M-stage forwarding source).
- m_addr  out  32  registered e_aluout, driven to memory.
- m_byteen  out  4  store byte enables.
- m_wdata  out  32  lane-shifted store data.
- m_ldata  out  32  extended load result.
- m_exc  out  5  final exception code for CP0.

Behaviour:
- Register update (E/M register fields instr, pc, bd, out, addr, store data, exc):
  - reset=0, asynchronously: instr=0, pc=0, bd=0, out=0, addr=0, store data=0, exc=0.
  - req=1 at a rising edge: instr=0, exc=0, bd=0, out=0, addr=0, store data=0, pc=EXC_HANDLER.
  - Otherwise the register loads its E inputs every edge. There is no stall input; E-side stalls arrive as bubbles (instr=0).
- Decoding uses the opcode m_instr[31:26]:
  - lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - sw 0x2B, sh 0x29, sb 0x28.
  - Any other opcode is neither a load nor a store.
- Address classes. Let a = m_addr.
  - DM: a <= DM_TOP.
  - T0: TIMER0_BASE <= a < TIMER0_BASE+12.
  - T1: TIMER1_BASE <= a < TIMER1_BASE+12.
  - IG: IG_BASE <= a < IG_BASE+4.
  - Any other address is out of range.
- Exception priority, combinational from registered state:
  - Registered exc != 0: pass it through unchanged. This also covers overflow-on-address, already coded 4/5 by E.
  - Load and any of the following: m_exc=4.
    - misaligned: lw a[1:0]!=0; lh/lhu a[0]!=0.
    - lh/lhu/lb/lbu to T0/T1/IG.
    - out of range.
  - Store and any of the following: m_exc=5.
    - misaligned.
    - sh/sb to T0/T1/IG.
    - out of range.
    - write to a timer Count register (offset 8 in T0/T1).
  - Otherwise m_exc=0.
- Byte enables:
  - sw: 4'b1111.
  - sh: 4'b0011 << a[1:0].
  - sb: 4'b0001 << a[1:0].
  - Forced to 0 when the instruction is not a store, m_exc!=0, or req=1. req gates the enables combinationally in the same cycle.
- Write data:
  - sw: data unchanged.
  - sh: data[15:0] replicated to both halves.
  - sb: data[7:0] replicated to all four bytes.
- Load data:
  - lw: m_rdata.
  - lh/lhu: halfword a[1] of m_rdata, sign-/zero-extended.
  - lb/lbu: byte a[1:0] of m_rdata, sign-/zero-extended.
  - Non-load: m_rdata passed through.
- Latency: one register stage from E inputs to all outputs. No further cycles; the stage holds no internal state beyond the register.

Decomposition:
- Shared package `mips_defs`:
  - opcode constants (lw/lh/lhu/lb/lbu/sw/sh/sb);
  - exception codes EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5, EXC_OV=12;
  - address-map constants.
- One natural sub-module, `mem_ext`: the purely combinational load extender (address low bits, opcode, word in → extended word out).

Test Plan:
- sw to a=0x0000_0104, data 0xDEADBEEF -> byteen=1111, wdata=0xDEADBEEF, m_exc=0.
- sb to a=0x0000_0103, data 0x000000A5 -> byteen=1000, wdata=0xA5A5A5A5.
- lh at a=0x0000_0002, m_rdata=0x8001_1234 -> m_ldata=0xFFFF_8001; same address with lhu -> 0x0000_8001.
- lw at a=0x0000_0006 -> m_exc=4, byteen=0000.
- sw to 0x0000_7F08 -> m_exc=5.
- sh to 0x0000_7F20 -> m_exc=5.
- em_exc=12 on sw to 0x0000_0001 -> m_exc=12 (upstream code wins), byteen=0000.
- sw in M with req=1 -> byteen=0000 in that cycle; next cycle instr=0, pc=0x0000_4180, exc=0.
- Assert reset=0 asynchronously mid-cycle -> all registered outputs become 0 immediately.
